flopoco_fmax_reduce: RTL and testbench

Streaming max-reduction stage that sits directly downstream of the FloPoCo floating-point less-than comparator (fcmplt). It consumes that comparator's XltY and unordered results and folds fixed-length groups of N FloPoCo-format operands into one maximum value plus the index of that value. It drives the comparator's X and Y inputs itself and serves the max-pool and argmax kernels of the generated datapath.

---
 rtl/flopoco_fmax_reduce_if.sv | 33 +++
 rtl/flopoco_fmax_reduce.sv | 119 +++++++++++
 tb/tb_flopoco_fmax_reduce.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/flopoco_fmax_reduce_if.sv
// rtl/flopoco_fmax_reduce_if.sv - stream, comparator and result signals of the max-reduction stage
interface flopoco_fmax_reduce_if #(
    parameter int WE   = 7,
    parameter int WF   = 7,
    parameter int IDXW = 2
);
    localparam int W = WE + WF + 3;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic [W-1:0]    cmp_x;
    logic [W-1:0]    cmp_y;
    logic            cmp_xlty;
    logic            cmp_unordered;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [IDXW-1:0] out_idx;
    logic            out_nan;

    // reduction stage side
    modport slave (
        input  in_valid, in_data, cmp_xlty, cmp_unordered, out_ready,
        output in_ready, cmp_x, cmp_y, out_valid, out_data, out_idx, out_nan
    );

    // producer / comparator / consumer side
    modport master (
        output in_valid, in_data, cmp_xlty, cmp_unordered, out_ready,
        input  in_ready, cmp_x, cmp_y, out_valid, out_data, out_idx, out_nan
    );
endinterface

// File: rtl/flopoco_fmax_reduce.sv
// rtl/flopoco_fmax_reduce.sv - folds groups of N FloPoCo operands into max value, index and NaN flag
module flopoco_fmax_reduce #(
    parameter int WE   = 7,
    parameter int WF   = 7,
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    flopoco_fmax_reduce_if.slave  bus
);
    localparam int              W         = WE + WF + 3;
    localparam logic [IDXW-1:0] LAST      = IDXW'(N - 1);
    localparam logic [W-1:0]    CANON_NAN = {2'b11, {(W-2){1'b0}}};

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACC   = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_nxt;
    logic [IDXW-1:0] cnt;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] idx_nxt;
    logic            nan_flag;
    logic            nan_nxt;
    logic            accept;

    assign accept = bus.in_valid & bus.in_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: collect N accepts, then hold the result until it is taken
    always_comb begin
        state_nxt = state;
        case (state)
            S_FIRST: if (accept) state_nxt = (N == 1) ? S_OUT : S_ACC;
            S_ACC:   if (accept && cnt == LAST) state_nxt = S_OUT;
            S_OUT:   if (bus.out_ready) state_nxt = S_FIRST;
            default: state_nxt = S_FIRST;
        endcase
    end

    // outputs decoded from state; comparator always sees accumulator vs. incoming operand
    always_comb begin
        bus.in_ready = (state != S_OUT);
        bus.cmp_x    = acc;
        bus.cmp_y    = bus.in_data;
    end

    // candidate accumulator update for the element being offered this cycle
    always_comb begin
        acc_nxt = acc;
        idx_nxt = idx;
        nan_nxt = nan_flag;
        if (state == S_FIRST) begin
            // first element seeds the accumulator; comparator result is stale here
            acc_nxt = bus.in_data;
            idx_nxt = '0;
            nan_nxt = (bus.in_data[W-1:W-2] == 2'b11);
        end else if (state == S_ACC) begin
            // strict less-than keeps the earliest of equal values
            if (bus.cmp_xlty) begin
                acc_nxt = bus.in_data;
                idx_nxt = cnt;
            end
            nan_nxt = nan_flag | bus.cmp_unordered;
        end
    end

    // accumulator, index, NaN flag and element counter
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            idx      <= '0;
            nan_flag <= 1'b0;
            cnt      <= '0;
        end else if (accept) begin
            acc      <= acc_nxt;
            idx      <= idx_nxt;
            nan_flag <= nan_nxt;
            if (state_nxt == S_OUT) begin
                cnt <= '0;
            end else if (state == S_FIRST) begin
                cnt <= IDXW'(1);
            end else begin
                cnt <= cnt + IDXW'(1);
            end
        end
    end

    // result register: loaded on the last accept, held until the downstream handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_idx   <= '0;
            bus.out_nan   <= 1'b0;
        end else if (accept && state_nxt == S_OUT) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= nan_nxt ? CANON_NAN : acc_nxt;
            bus.out_idx   <= idx_nxt;
            bus.out_nan   <= nan_nxt;
        end else if (state == S_OUT && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_flopoco_fmax_reduce.sv
// tb/tb_flopoco_fmax_reduce.sv - table-driven and sequence checks of the max-reduction stage
module tb_flopoco_fmax_reduce;
    localparam logic [16:0] ONE  = 17'h09F80;
    localparam logic [16:0] TWO  = 17'h0A000;
    localparam logic [16:0] MONE = 17'h0DF80;
    localparam logic [16:0] PZ   = 17'h00000;
    localparam logic [16:0] MZ   = 17'h04000;
    localparam logic [16:0] PINF = 17'h10000;
    localparam logic [16:0] MINF = 17'h14000;
    localparam logic [16:0] QNAN = 17'h18000;

    typedef struct {
        logic [16:0] d0, d1, d2, d3;
        logic [16:0] ed;
        logic [1:0]  ei;
        logic        en;
        logic        ci;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    flopoco_fmax_reduce_if #(.WE(7), .WF(7), .IDXW(2)) b4 ();
    flopoco_fmax_reduce_if #(.WE(7), .WF(7), .IDXW(1)) b1 ();

    flopoco_fmax_reduce #(.WE(7), .WF(7), .N(4), .IDXW(2)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    flopoco_fmax_reduce #(.WE(7), .WF(7), .N(1), .IDXW(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    // reference FloPoCo less-than: returns {x<y, unordered}
    function automatic logic [1:0] fcmp(input logic [16:0] x, input logic [16:0] y);
        logic [1:0]  ex, ey;
        logic [15:0] mx, my;
        logic        lt;
        ex = x[16:15];
        ey = y[16:15];
        if (ex == 2'b11 || ey == 2'b11) return 2'b01;
        mx = (ex == 2'b00) ? 16'h0 : (ex == 2'b10) ? 16'h8000 : {2'b01, x[13:0]};
        my = (ey == 2'b00) ? 16'h0 : (ey == 2'b10) ? 16'h8000 : {2'b01, y[13:0]};
        if (mx == 16'h0 && my == 16'h0) lt = 1'b0;
        else if (x[14] != y[14])        lt = x[14];
        else if (!x[14])                lt = (mx < my);
        else                            lt = (mx > my);
        return {lt, 1'b0};
    endfunction

    assign {b4.cmp_xlty, b4.cmp_unordered} = fcmp(b4.cmp_x, b4.cmp_y);
    assign {b1.cmp_xlty, b1.cmp_unordered} = fcmp(b1.cmp_x, b1.cmp_y);

    function automatic vec_t mk(input logic [16:0] a, input logic [16:0] b, input logic [16:0] c,
                                input logic [16:0] d, input logic [16:0] ed, input logic [1:0] ei,
                                input logic en, input logic ci);
        vec_t v;
        v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d;
        v.ed = ed; v.ei = ei; v.en = en; v.ci = ci;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[7];
        logic [16:0] el[4];

        vecs[0] = mk(ONE,  MONE, TWO,  ONE,  TWO,  2'd2, 1'b0, 1'b1);
        vecs[1] = mk(MZ,   PZ,   MONE, MZ,   MZ,   2'd0, 1'b0, 1'b1);
        vecs[2] = mk(TWO,  QNAN, ONE,  PINF, QNAN, 2'd0, 1'b1, 1'b0);
        vecs[3] = mk(ONE,  ONE,  ONE,  ONE,  ONE,  2'd0, 1'b0, 1'b1);
        vecs[4] = mk(MINF, MONE, PZ,   TWO,  TWO,  2'd3, 1'b0, 1'b1);
        vecs[5] = mk(PINF, ONE,  TWO,  QNAN, QNAN, 2'd0, 1'b1, 1'b0);
        vecs[6] = mk(TWO,  MONE, ONE,  MINF, TWO,  2'd0, 1'b0, 1'b1);

        b4.in_valid = 1'b0; b4.in_data = '0; b4.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset out_valid", 32'(b4.out_valid), 32'd0);
        chk("reset out_data",  32'(b4.out_data),  32'd0);
        chk("reset out_idx",   32'(b4.out_idx),   32'd0);
        chk("reset out_nan",   32'(b4.out_nan),   32'd0);
        chk("reset in_ready",  32'(b4.in_ready),  32'd1);
        chk("reset cmp_x",     32'(b4.cmp_x),     32'd0);
        b4.in_data = ONE;
        #1;
        chk("cmp_y passthrough", 32'(b4.cmp_y), 32'(ONE));

        // back-to-back groups with out_ready held high
        for (int v = 0; v < 7; v++) begin
            el[0] = vecs[v].d0; el[1] = vecs[v].d1; el[2] = vecs[v].d2; el[3] = vecs[v].d3;
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("v%0d in_ready e%0d", v, k), 32'(b4.in_ready), 32'd1);
                b4.in_valid = 1'b1;
                b4.in_data  = el[k];
                tick();
                if (k < 3) chk($sformatf("v%0d early out_valid e%0d", v, k), 32'(b4.out_valid), 32'd0);
            end
            b4.in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", v), 32'(b4.out_valid), 32'd1);
            chk($sformatf("v%0d out_data", v),  32'(b4.out_data),  32'(vecs[v].ed));
            chk($sformatf("v%0d out_nan", v),   32'(b4.out_nan),   32'(vecs[v].en));
            if (vecs[v].ci) chk($sformatf("v%0d out_idx", v), 32'(b4.out_idx), 32'(vecs[v].ei));
            chk($sformatf("v%0d in_ready low", v), 32'(b4.in_ready), 32'd0);
            tick();
            chk($sformatf("v%0d out_valid drop", v), 32'(b4.out_valid), 32'd0);
            chk($sformatf("v%0d in_ready back", v), 32'(b4.in_ready), 32'd1);
        end

        // input stall mid-group has no side effects
        b4.in_valid = 1'b1; b4.in_data = MONE; tick();
        b4.in_data = TWO; tick();
        b4.in_valid = 1'b0; b4.in_data = PINF; repeat (3) tick();
        b4.in_valid = 1'b1; b4.in_data = ONE; tick();
        b4.in_data = MONE; tick();
        b4.in_valid = 1'b0;
        chk("stall out_valid", 32'(b4.out_valid), 32'd1);
        chk("stall out_data",  32'(b4.out_data),  32'(TWO));
        chk("stall out_idx",   32'(b4.out_idx),   32'd1);
        tick();

        // output backpressure: result held, input refused
        b4.out_ready = 1'b0;
        el[0] = ONE; el[1] = PINF; el[2] = TWO; el[3] = TWO;
        for (int k = 0; k < 4; k++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = el[k];
            tick();
        end
        b4.in_data = MONE;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp out_valid c%0d", c), 32'(b4.out_valid), 32'd1);
            chk($sformatf("bp out_data c%0d", c),  32'(b4.out_data),  32'(PINF));
            chk($sformatf("bp out_idx c%0d", c),   32'(b4.out_idx),   32'd1);
            chk($sformatf("bp in_ready c%0d", c),  32'(b4.in_ready),  32'd0);
            if (c < 4) tick();
        end
        b4.in_valid = 1'b0;
        b4.out_ready = 1'b1;
        tick();
        chk("bp release out_valid", 32'(b4.out_valid), 32'd0);
        chk("bp release in_ready",  32'(b4.in_ready),  32'd1);

        // reset mid-group discards partial data
        b4.in_valid = 1'b1; b4.in_data = TWO; repeat (2) tick();
        b4.in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst mid out_valid", 32'(b4.out_valid), 32'd0);
        chk("rst mid cmp_x",     32'(b4.cmp_x),     32'd0);
        for (int k = 0; k < 4; k++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = MONE;
            tick();
            if (k < 3) chk($sformatf("rst grp early out_valid e%0d", k), 32'(b4.out_valid), 32'd0);
        end
        b4.in_valid = 1'b0;
        chk("rst grp out_valid", 32'(b4.out_valid), 32'd1);
        chk("rst grp out_data",  32'(b4.out_data),  32'(MONE));
        chk("rst grp out_idx",   32'(b4.out_idx),   32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rst grp single result c%0d", c), 32'(b4.out_valid), 32'd0);
        end

        // N=1 build: every element is its own group
        b1.in_valid = 1'b1; b1.in_data = ONE;
        tick();
        chk("n1 first out_valid", 32'(b1.out_valid), 32'd1);
        chk("n1 first out_data",  32'(b1.out_data),  32'(ONE));
        chk("n1 first out_idx",   32'(b1.out_idx),   32'd0);
        chk("n1 first in_ready",  32'(b1.in_ready),  32'd0);
        b1.in_data = TWO; b1.out_ready = 1'b1;
        tick();
        chk("n1 handshake out_valid", 32'(b1.out_valid), 32'd0);
        chk("n1 handshake in_ready",  32'(b1.in_ready),  32'd1);
        tick();
        b1.in_valid = 1'b0;
        chk("n1 second out_valid", 32'(b1.out_valid), 32'd1);
        chk("n1 second out_data",  32'(b1.out_data),  32'(TWO));
        chk("n1 second out_idx",   32'(b1.out_idx),   32'd0);
        tick();
        chk("n1 idle out_valid", 32'(b1.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
